// File: rtl/gemm_ctrl.sv
// gemm_ctrl: sequencing engine for an int8 GEMM over a single word-wide memory port.
// Walks i (rows of lhs), j (rows of transposed rhs), k (reduction) and writes int32 dst words.
// Optional build macro GEMM_CTRL_LHS_OFFSET_EN adds an lhs_offset port whose low 9 bits
// (signed) are added to every lhs byte before the multiply.
//
// Memory handshake: a request is presented when mem_req_valid=1 and completes on the rising
// edge where mem_req_ready=1; valid/addr/read/wdata hold stable until then and valid drops the
// following cycle. Exactly one request is outstanding; its completion is the next
// mem_rsp_valid, which is always accepted and ignored when nothing is outstanding.
module gemm_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              nice_clk,
  input  logic              nice_rst_n,
  input  logic              start,
  input  logic [31:0]       lhs_cols,
  input  logic [31:0]       lhs_rows,
  input  logic [31:0]       rhs_cols,
  input  logic [31:0]       lhs_addr,
  input  logic [31:0]       rhs_addr,
  input  logic [31:0]       dst_addr,
`ifdef GEMM_CTRL_LHS_OFFSET_EN
  input  logic [31:0]       lhs_offset,
`endif
  output logic [1:0]        state,
  output logic              fin,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_read,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CALC  = 2'b01,
    ST_STORE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // Sub-phase of CALC/STORE; tracks which request is in flight.
  typedef enum logic [2:0] {
    PH_ISSUE, PH_LHS_REQ, PH_LHS_RSP, PH_RHS_REQ, PH_RHS_RSP, PH_MAC, PH_WR_REQ, PH_WR_RSP
  } phase_e;

  state_e state_q, state_d;
  phase_e phase_q, phase_d;
  logic [31:0] m_q, m_d, kl_q, kl_d, n_q, n_d;
  logic [31:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [31:0] lhs_row_q, lhs_row_d, lhs_ptr_q, lhs_ptr_d;
  logic [31:0] rhs_base_q, rhs_base_d, rhs_ptr_q, rhs_ptr_d, dst_ptr_q, dst_ptr_d;
  logic [31:0] acc_q, acc_d, prod_ext;
  logic [7:0]  lhs_b_q, lhs_b_d, rhs_b_q, rhs_b_d;
  logic [1:0]  bsel_q, bsel_d;
  logic              req_valid_q, req_valid_d, req_read_q, req_read_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [31:0]       req_wdata_q, req_wdata_d;

  // Little-endian byte pick within a word.
  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] s);
    case (s)
      2'd0:    pick_byte = w[7:0];
      2'd1:    pick_byte = w[15:8];
      2'd2:    pick_byte = w[23:16];
      default: pick_byte = w[31:24];
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] word_addr(input logic [31:0] p);
    word_addr = ADDR_W'({p[31:2], 2'b00});
  endfunction

`ifdef GEMM_CTRL_LHS_OFFSET_EN
  logic [8:0]         off_q;
  logic signed [8:0]  lhs_adj;
  logic signed [16:0] prod;
  logic               unused_off;
  assign unused_off = ^lhs_offset[31:9];
  assign lhs_adj    = $signed({lhs_b_q[7], lhs_b_q}) + $signed(off_q);
  assign prod       = lhs_adj * $signed(rhs_b_q);
  assign prod_ext   = {{15{prod[16]}}, prod};

  // Offset is captured alongside the other launch parameters.
  always_ff @(posedge nice_clk or negedge nice_rst_n) begin
    if (!nice_rst_n) off_q <= '0;
    else if (state_q == ST_IDLE && start) off_q <= lhs_offset[8:0];
  end
`else
  logic signed [15:0] prod;
  assign prod     = $signed(lhs_b_q) * $signed(rhs_b_q);
  assign prod_ext = {{16{prod[15]}}, prod};
`endif

  // Next-state, loop-counter, pointer and request logic.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    m_d         = m_q;
    kl_d        = kl_q;
    n_d         = n_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    lhs_row_d   = lhs_row_q;
    lhs_ptr_d   = lhs_ptr_q;
    rhs_base_d  = rhs_base_q;
    rhs_ptr_d   = rhs_ptr_q;
    dst_ptr_d   = dst_ptr_q;
    acc_d       = acc_q;
    lhs_b_d     = lhs_b_q;
    rhs_b_d     = rhs_b_q;
    bsel_d      = bsel_q;
    req_valid_d = req_valid_q;
    req_read_d  = req_read_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          m_d        = lhs_rows;
          kl_d       = lhs_cols;
          n_d        = rhs_cols;
          lhs_row_d  = lhs_addr;
          lhs_ptr_d  = lhs_addr;
          rhs_base_d = rhs_addr;
          rhs_ptr_d  = rhs_addr;
          dst_ptr_d  = dst_addr;
          i_d        = '0;
          j_d        = '0;
          k_d        = '0;
          acc_d      = '0;
          phase_d    = PH_ISSUE;
          if (lhs_rows == '0 || lhs_cols == '0 || rhs_cols == '0) state_d = ST_DONE;
          else                                                    state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        case (phase_q)
          PH_ISSUE: begin
            req_valid_d = 1'b1;
            req_read_d  = 1'b1;
            req_addr_d  = word_addr(lhs_ptr_q);
            bsel_d      = lhs_ptr_q[1:0];
            phase_d     = PH_LHS_REQ;
          end
          PH_LHS_REQ: if (mem_req_ready) begin
            req_valid_d = 1'b0;
            phase_d     = PH_LHS_RSP;
          end
          PH_LHS_RSP: if (mem_rsp_valid) begin
            lhs_b_d     = pick_byte(mem_rsp_rdata, bsel_q);
            req_valid_d = 1'b1;
            req_read_d  = 1'b1;
            req_addr_d  = word_addr(rhs_ptr_q);
            bsel_d      = rhs_ptr_q[1:0];
            phase_d     = PH_RHS_REQ;
          end
          PH_RHS_REQ: if (mem_req_ready) begin
            req_valid_d = 1'b0;
            phase_d     = PH_RHS_RSP;
          end
          PH_RHS_RSP: if (mem_rsp_valid) begin
            rhs_b_d = pick_byte(mem_rsp_rdata, bsel_q);
            phase_d = PH_MAC;
          end
          PH_MAC: begin
            acc_d       = acc_q + prod_ext;
            lhs_ptr_d   = lhs_ptr_q + 32'd1;
            rhs_ptr_d   = rhs_ptr_q + 32'd1;
            req_valid_d = 1'b1;
            if (k_q == kl_q - 32'd1) begin
              k_d         = '0;
              state_d     = ST_STORE;
              req_read_d  = 1'b0;
              req_addr_d  = word_addr(dst_ptr_q);
              req_wdata_d = acc_q + prod_ext;
              phase_d     = PH_WR_REQ;
            end else begin
              k_d        = k_q + 32'd1;
              req_read_d = 1'b1;
              req_addr_d = word_addr(lhs_ptr_q + 32'd1);
              bsel_d     = lhs_ptr_q[1:0] + 2'd1;
              phase_d    = PH_LHS_REQ;
            end
          end
          default: phase_d = PH_ISSUE;
        endcase
      end
      ST_STORE: begin
        case (phase_q)
          PH_WR_REQ: if (mem_req_ready) begin
            req_valid_d = 1'b0;
            phase_d     = PH_WR_RSP;
          end
          PH_WR_RSP: if (mem_rsp_valid) begin
            dst_ptr_d = dst_ptr_q + 32'd4;
            acc_d     = '0;
            phase_d   = PH_ISSUE;
            state_d   = ST_CALC;
            if (j_q == n_q - 32'd1) begin
              // lhs_ptr already sits at the start of the next row.
              j_d       = '0;
              lhs_row_d = lhs_ptr_q;
              rhs_ptr_d = rhs_base_q;
              if (i_q == m_q - 32'd1) state_d = ST_DONE;
              else                    i_d     = i_q + 32'd1;
            end else begin
              // rhs is contiguous, so rhs_ptr already points at row j+1.
              j_d       = j_q + 32'd1;
              lhs_ptr_d = lhs_row_q;
            end
          end
          default: phase_d = PH_WR_REQ;
        endcase
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge nice_clk or negedge nice_rst_n) begin
    if (!nice_rst_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= PH_ISSUE;
      m_q         <= '0;
      kl_q        <= '0;
      n_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      lhs_row_q   <= '0;
      lhs_ptr_q   <= '0;
      rhs_base_q  <= '0;
      rhs_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      acc_q       <= '0;
      lhs_b_q     <= '0;
      rhs_b_q     <= '0;
      bsel_q      <= '0;
      req_valid_q <= 1'b0;
      req_read_q  <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      m_q         <= m_d;
      kl_q        <= kl_d;
      n_q         <= n_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      lhs_row_q   <= lhs_row_d;
      lhs_ptr_q   <= lhs_ptr_d;
      rhs_base_q  <= rhs_base_d;
      rhs_ptr_q   <= rhs_ptr_d;
      dst_ptr_q   <= dst_ptr_d;
      acc_q       <= acc_d;
      lhs_b_q     <= lhs_b_d;
      rhs_b_q     <= rhs_b_d;
      bsel_q      <= bsel_d;
      req_valid_q <= req_valid_d;
      req_read_q  <= req_read_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
    end
  end

  assign state         = state_q;
  assign fin           = (state_q == ST_DONE);
  assign mem_req_valid = req_valid_q;
  assign mem_req_read  = req_read_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_wdata = req_wdata_q;

endmodule

// File: tb/tb_gemm_ctrl.sv
// Directed bench for gemm_ctrl: byte memory model with programmable stall and response delay,
// write scoreboard, and a final one-line report.
module tb_gemm_ctrl;

  logic        nice_clk;
  logic        nice_rst_n;
  logic        start;
  logic [31:0] lhs_cols, lhs_rows, rhs_cols, lhs_addr, rhs_addr, dst_addr;
`ifdef GEMM_CTRL_LHS_OFFSET_EN
  logic [31:0] lhs_offset;
`endif
  logic [1:0]  state;
  logic        fin;
  logic        mem_req_valid, mem_req_ready, mem_req_read;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;

  gemm_ctrl #(.ADDR_W(32)) dut (
    .nice_clk      (nice_clk),
    .nice_rst_n    (nice_rst_n),
    .start         (start),
    .lhs_cols      (lhs_cols),
    .lhs_rows      (lhs_rows),
    .rhs_cols      (rhs_cols),
    .lhs_addr      (lhs_addr),
    .rhs_addr      (rhs_addr),
    .dst_addr      (dst_addr),
`ifdef GEMM_CTRL_LHS_OFFSET_EN
    .lhs_offset    (lhs_offset),
`endif
    .state         (state),
    .fin           (fin),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_read  (mem_req_read),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata)
  );

  // ---------------- clock / reset ----------------
  initial nice_clk = 1'b0;
  always #5 nice_clk = ~nice_clk;

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // ---------------- memory model + scoreboard ----------------
  logic [7:0]  mem [0:255];
  logic [63:0] exp_q[$];
  int          stall_cyc = 0;
  int          rsp_dly   = 1;
  int          reads     = 0;
  int          writes    = 0;
  int          rphase    = 0;
  int          cnt       = 0;
  int          dcnt      = 0;
  logic [31:0] cap_addr, cap_wdata;
  logic        cap_read;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0] & 8'hFC;
    word_at = {mem[b + 8'd3], mem[b + 8'd2], mem[b + 8'd1], mem[b]};
  endfunction

  task automatic mem_respond();
    logic [63:0] e;
    mem_rsp_valid = 1'b1;
    if (cap_read) begin
      reads++;
      mem_rsp_rdata = word_at(cap_addr);
    end else begin
      writes++;
      mem_rsp_rdata = 32'h0;
      check("wr_expected", (exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", cap_addr, e[63:32]);
        check("wr_data", cap_wdata, e[31:0]);
      end
    end
    rphase = 0;
  endtask

  initial begin
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = 32'h0;
    forever begin
      @(negedge nice_clk);
      mem_rsp_valid = 1'b0;
      if (!nice_rst_n) begin
        rphase        = 0;
        mem_req_ready = 1'b0;
      end else begin
        case (rphase)
          0: if (mem_req_valid) begin
            cap_addr  = mem_req_addr;
            cap_read  = mem_req_read;
            cap_wdata = mem_req_wdata;
            check("addr_aligned", {30'd0, mem_req_addr[1:0]}, 32'd0);
            cnt = 0;
            if (stall_cyc == 0) begin
              mem_req_ready = 1'b1;
              rphase        = 2;
            end else rphase = 1;
          end
          1: begin
            check("hold_valid", {31'd0, mem_req_valid}, 32'd1);
            check("hold_addr", mem_req_addr, cap_addr);
            check("hold_read", {31'd0, mem_req_read}, {31'd0, cap_read});
            check("hold_wdata", mem_req_wdata, cap_wdata);
            cnt++;
            if (cnt >= stall_cyc) begin
              mem_req_ready = 1'b1;
              rphase        = 2;
            end
          end
          2: begin
            mem_req_ready = 1'b0;
            check("one_outstanding", {31'd0, mem_req_valid}, 32'd0);
            dcnt = 1;
            if (dcnt >= rsp_dly) mem_respond();
            else rphase = 3;
          end
          default: begin
            check("one_outstanding", {31'd0, mem_req_valid}, 32'd0);
            dcnt++;
            if (dcnt >= rsp_dly) mem_respond();
          end
        endcase
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_mem();
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
  endtask

  task automatic setup(input logic [31:0] m, k, n, la, ra, da, input int stall, input int dly);
    lhs_rows  = m;
    lhs_cols  = k;
    rhs_cols  = n;
    lhs_addr  = la;
    rhs_addr  = ra;
    dst_addr  = da;
    stall_cyc = stall;
    rsp_dly   = dly;
    reads     = 0;
    writes    = 0;
  endtask

  task automatic pulse_start();
    @(negedge nice_clk);
    start = 1'b1;
    @(negedge nice_clk);
    start = 1'b0;
  endtask

  // Launch, wait for fin under a cycle budget, then check the one-cycle DONE.
  task automatic run_and_wait(input string tag);
    bit found;
    pulse_start();
    found = 0;
    for (int c = 0; c < 3000; c++) begin
      if (fin) begin
        found = 1;
        break;
      end
      @(negedge nice_clk);
    end
    check({tag, "_fin_seen"}, {31'd0, found}, 32'd1);
    if (found) begin
      check({tag, "_done_state"}, {30'd0, state}, 32'd3);
      @(negedge nice_clk);
      check({tag, "_fin_one_cycle"}, {31'd0, fin}, 32'd0);
      check({tag, "_back_idle"}, {30'd0, state}, 32'd0);
    end
    check({tag, "_all_writes_seen"}, exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, {30'd0, state}, 32'd0);
    check({tag, "_fin"}, {31'd0, fin}, 32'd0);
    check({tag, "_valid"}, {31'd0, mem_req_valid}, 32'd0);
    check({tag, "_read"}, {31'd0, mem_req_read}, 32'd0);
    check({tag, "_addr"}, mem_req_addr, 32'd0);
    check({tag, "_wdata"}, mem_req_wdata, 32'd0);
  endtask

  // 2x3x2 fixture: lhs=[1,2,3;4,5,6] at 0x01 (unaligned), rhs rows [1,0,-1],[2,2,2] at 0x30.
  task automatic load_small();
    clear_mem();
    mem[8'h01] = 8'd1; mem[8'h02] = 8'd2; mem[8'h03] = 8'd3;
    mem[8'h04] = 8'd4; mem[8'h05] = 8'd5; mem[8'h06] = 8'd6;
    mem[8'h30] = 8'd1; mem[8'h31] = 8'd0; mem[8'h32] = 8'hFF;
    mem[8'h33] = 8'd2; mem[8'h34] = 8'd2; mem[8'h35] = 8'd2;
    exp_q.delete();
    exp_q.push_back({32'h80, 32'hFFFFFFFE});
    exp_q.push_back({32'h84, 32'd12});
    exp_q.push_back({32'h88, 32'hFFFFFFFE});
    exp_q.push_back({32'h8C, 32'd30});
  endtask

  // ---------------- test sequence ----------------
  initial begin
    nice_rst_n = 1'b0;
    start      = 1'b0;
`ifdef GEMM_CTRL_LHS_OFFSET_EN
    lhs_offset = 32'd0;
`endif
    setup(0, 0, 0, 0, 0, 0, 0, 1);
    clear_mem();
    repeat (3) @(negedge nice_clk);
    check_reset_outputs("reset");
    nice_rst_n = 1'b1;
    @(negedge nice_clk);

    // Single element, unaligned bases: 3 * -4 = -12.
    clear_mem();
    mem[8'h11] = 8'd3;
    mem[8'h23] = 8'hFC;
    exp_q.delete();
    exp_q.push_back({32'h40, 32'hFFFFFFF4});
    setup(1, 1, 1, 32'h11, 32'h23, 32'h40, 0, 1);
    run_and_wait("single");
    check("single_reads", reads, 32'd2);
    check("single_writes", writes, 32'd1);

    // Extreme int8 product: -128 * -128 = 16384.
    clear_mem();
    mem[8'h10] = 8'h80;
    mem[8'h20] = 8'h80;
    exp_q.delete();
    exp_q.push_back({32'h40, 32'h00004000});
    setup(1, 1, 1, 32'h10, 32'h20, 32'h40, 0, 1);
    run_and_wait("minmin");

    // Small GEMM, zero-wait memory.
    load_small();
    setup(2, 3, 2, 32'h01, 32'h30, 32'h80, 0, 1);
    run_and_wait("gemm");
    check("gemm_reads", reads, 32'd24);
    check("gemm_writes", writes, 32'd4);

    // Same GEMM under backpressure: 7 stall cycles, response delay 3.
    load_small();
    setup(2, 3, 2, 32'h01, 32'h30, 32'h80, 7, 3);
    run_and_wait("bp");
    check("bp_reads", reads, 32'd24);
    check("bp_writes", writes, 32'd4);

    // Zero K: straight to DONE, no memory traffic.
    exp_q.delete();
    setup(2, 0, 2, 32'h01, 32'h30, 32'h80, 0, 1);
    check("zero_idle_before", {30'd0, state}, 32'd0);
    pulse_start();
    check("zero_state_done", {30'd0, state}, 32'd3);
    check("zero_fin", {31'd0, fin}, 32'd1);
    check("zero_no_req0", {31'd0, mem_req_valid}, 32'd0);
    @(negedge nice_clk);
    check("zero_state_idle", {30'd0, state}, 32'd0);
    check("zero_fin_low", {31'd0, fin}, 32'd0);
    check("zero_no_req1", {31'd0, mem_req_valid}, 32'd0);
    @(negedge nice_clk);
    check("zero_no_req2", {31'd0, mem_req_valid}, 32'd0);
    check("zero_reads", reads, 32'd0);
    check("zero_writes", writes, 32'd0);

    // Reset in the middle of CALC, then a fresh run must still be correct.
    load_small();
    exp_q.delete();
    setup(2, 3, 2, 32'h01, 32'h30, 32'h80, 0, 1);
    pulse_start();
    repeat (8) @(negedge nice_clk);
    check("midrst_in_calc", {30'd0, state}, 32'd1);
    #2 nice_rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (2) @(negedge nice_clk);
    check_reset_outputs("midrst_hold");
    #2 nice_rst_n = 1'b1;
    load_small();
    setup(2, 3, 2, 32'h01, 32'h30, 32'h80, 0, 1);
    run_and_wait("after_rst");
    check("after_rst_reads", reads, 32'd24);
    check("after_rst_writes", writes, 32'd4);

`ifdef GEMM_CTRL_LHS_OFFSET_EN
    // lhs -128 shifted by +128 gives 0, so 0 * 5 = 0.
    clear_mem();
    mem[8'h10] = 8'h80;
    mem[8'h20] = 8'd5;
    mem[8'h40] = 8'hAA;
    exp_q.delete();
    exp_q.push_back({32'h40, 32'h0});
    lhs_offset = 32'd128;
    setup(1, 1, 1, 32'h10, 32'h20, 32'h40, 0, 1);
    run_and_wait("offset");
    lhs_offset = 32'd0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gemm_ctrl.md
# gemm_ctrl

Sequencing engine of the GEMM accelerator. It sits directly downstream of the NICE parameter-transfer block and consumes its latched matrix dimensions, base addresses and single-cycle `start` pulse. It walks an int8 M×K × K×N product over a single word-wide memory port and writes int32 results. It reports `state` back upstream, which gates NICE request acceptance, and pulses `fin` to raise the multi-cycle response.

## Interface
- `ADDR_W`, default 32: address width of the memory port.
- `nice_clk` in 1: sole clock; all logic is rising-edge.
- `nice_rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle launch pulse. Honoured only while `state==2'b00`.
- `lhs_cols` in 32: K, the reduction length.
- `lhs_rows` in 32: M, the number of output rows.
- `rhs_cols` in 32: N, the number of output columns.
- `lhs_addr`, `rhs_addr`, `dst_addr` in 32: byte base addresses.
- `lhs_offset` in 32: present only with `GEMM_CTRL_LHS_OFFSET_EN`.
- `state` out 2: 00 IDLE, 01 CALC, 10 STORE, 11 DONE.
- `fin` out 1: one-cycle completion pulse.
- `mem_req_valid` out 1, `mem_req_ready` in 1: request handshake.
- `mem_req_read` out 1: 1 = read, 0 = write.
- `mem_req_addr` out ADDR_W: word-aligned address (bits [1:0]=0).
- `mem_req_wdata` out 32: write data.
- `mem_rsp_valid` in 1, `mem_rsp_rdata` in 32: read/write completion. Always accepted; no ready.

## Operation
- Data layout:
  - lhs[i][k] is at `lhs_addr+i*K+k`.
  - rhs[j][k] is at `rhs_addr+j*K+k`; rhs is stored transposed, N rows of K.
  - dst[i][j] is a 32-bit word at `dst_addr+4*(i*N+j)`.
- On accepted `start`, latch M, K, N and the three bases into internal registers. Upstream changes after that are ignored until IDLE.
- If M, K or N is 0: go straight to DONE. No memory traffic; `fin` still pulses.
- CALC loops over i (outer), j, k (inner). For each k:
  - Issue a read of the lhs word. On response, select byte `addr[1:0]` (little-endian) and sign-extend.
  - Issue a read of the rhs word and select its byte the same way.
  - `acc <= acc + lhs_b*rhs_b`. The product is 16-bit signed; the accumulator is 32-bit two's-complement and wraps.
- `acc` clears to 0 at the start of each (i,j).
- After k=K-1, enter STORE:
  - Write `acc` to the dst word.
  - Wait for `mem_rsp_valid`.
  - Advance j, then i. Return to CALC, or go to DONE after the last element.
- DONE lasts exactly one cycle, with `fin=1`, then IDLE.
- Exactly one memory request is outstanding at any time. The next request is never issued before `mem_rsp_valid` of the previous one.
- Index and address arithmetic is 32-bit unsigned with wrap. Addresses are kept as running pointers:
  - The lhs pointer rewinds to the row start for each j.
  - The rhs pointer rewinds to `rhs_addr` for each i.
  - The dst pointer advances by 4 per store.
  - No multiplies by M/N/K in the address path.

## Timing
- Reset values: `state=00`, `fin=0`, `mem_req_valid=0`, `mem_req_read=0`, `mem_req_addr=0`, `mem_req_wdata=0`. All counters and `acc` are 0.
- Reset mid-operation aborts immediately and drops `mem_req_valid`. Late `mem_rsp_valid` after reset is ignored.
- `state` leaves 00 on the cycle after `start` is sampled.
- Request rules:
  - The first `mem_req_valid` rises the cycle after `state` leaves 00.
  - Once raised, `mem_req_valid`, address, read flag and data are held stable until the cycle where `mem_req_ready=1`.
  - The request drops the following cycle.
- Memory responses:
  - The earliest response is the cycle after the handshake. The response may arrive in the same cycle as a later `ready` only for a different request; impossible by construction.
  - A response arriving while no request is outstanding is ignored.
- MAC latency:
  - The MAC update happens in the cycle after the rhs response.
  - The next lhs request is issued in that same cycle.
  - Each k costs ≥5 cycles with zero-wait memory.
- `start` while `state!=00` is ignored; upstream also blocks it via ready.
- The `fin` pulse coincides with `state==11`. `state==00` is restored the next cycle.

## Configuration
- `GEMM_CTRL_LHS_OFFSET_EN` defined:
  - The `lhs_offset` port exists and is latched at `start`.
  - The multiply becomes `(lhs_b + lhs_offset[8:0] as signed 9-bit) * rhs_b`, a 17-bit signed product.
- Not defined: no port; the plain int8 product is used.

## Test plan
- Single element: M=K=N=1, lhs byte=3, rhs byte=0xFC (−4). Expect one write of 0xFFFFFFF4 to `dst_addr`, then a one-cycle `fin`.
- Small GEMM, M=2, K=3, N=2, with lhs=[1,2,3;4,5,6] and rhs rows [1,0,−1] and [2,2,2]:
  - Expect dst = −2, 12, −2, 30 at offsets +0, +4, +8, +12.
  - Expect exactly 2*2*3*2 reads and 4 writes.
- Zero dimension: K=0 with valid start. Expect no `mem_req_valid`, `fin` 2 cycles after start, and `state` sequence 00→11→00.
- Backpressure: hold `mem_req_ready=0` for 7 cycles on each request, with response delay 3. Expect identical results to the zero-wait case, and addr/data stable throughout each stall.
- Reset mid-CALC: assert `nice_rst_n=0` on the 10th cycle of a 2×3×2 run. Expect all outputs at reset values, and a fresh start afterwards to complete correctly.
- With `GEMM_CTRL_LHS_OFFSET_EN`: M=K=N=1, lhs=0x80 (−128), lhs_offset=128, rhs=5. Expect dst=0.
